operand_streamer: RTL and testbench
===================================

Name: operand_streamer

Overview:
- Upstream feeder for the matrix compute stage.
- Holds a host-written operand store for A (2 x K, row-major) and B (K x 2, row-major).
- On start, replays A as one AXI-Stream packet of 2*cfg_k beats, then B as one packet of 2*cfg_k beats, each with tlast on its final beat.
- The stream order matches exactly what the compute stage's LOAD_A/LOAD_B phases consume.

Parameters:
- DATA_W, 32, operand word width
- K_MAX, 64, maximum inner dimension; each bank holds 2*K_MAX words
- ADDR_W, $clog2(2*K_MAX), host write address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  host write strobe
- wr_sel  in  1  bank select: 0 = A, 1 = B
- wr_addr  in  ADDR_W  linear word address within the bank
- wr_data  in  DATA_W  write data
- cfg_k  in  16  inner dimension, sampled at start
- start  in  1  level request to stream
- busy  out  1  high in STREAM_A, STREAM_B, DONE
- done  out  1  high in DONE
- err  out  1  one-cycle error pulse
- m_axis_a_tdata/tvalid/tlast  out  DATA_W/1/1  A stream
- m_axis_a_tready  in  1  A stream ready
- m_axis_b_tdata/tvalid/tlast  out  DATA_W/1/1  B stream
- m_axis_b_tready  in  1  B stream ready

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0; state IDLE; counters 0. Bank contents are not reset.
- Host writes:
  - Accepted only in IDLE, with wr_addr < 2*K_MAX.
  - A write while busy, or with an out-of-range address, is dropped and pulses err for one cycle.
- FSM states: IDLE, STREAM_A, STREAM_B, DONE.
  - IDLE -> STREAM_A: start=1 and 1 <= cfg_k <= K_MAX. cfg_k is latched into k_lat; beat counter is cleared.
  - IDLE stays IDLE with an err pulse: start=1 and cfg_k is 0 or greater than K_MAX.
  - STREAM_A -> STREAM_B: on the handshake of the A beat carrying tlast.
  - STREAM_B -> DONE: on the handshake of the B beat carrying tlast.
  - DONE -> IDLE: when start=0.
- Output slice (per stream): registered tdata/tvalid/tlast.
  - Loaded from bank[beat_cnt] when the state is active, the beat counter is not exhausted, and (!tvalid || tready).
  - tdata and tlast are held stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
- Latency:
  - First A tvalid is 1 cycle after entering STREAM_A.
  - First B tvalid is 1 cycle after entering STREAM_B.
  - Sustained rate is 1 beat/cycle with tready tied high.
- Beat counter:
  - Width ADDR_W+1; reset to 0 on each state entry.
  - Increments on each slice load; no wrap.
  - tlast is set on the beat loaded from address 2*k_lat-1.
- A and B tvalid are never high in the same cycle.
- No beats are emitted beyond 2*k_lat per stream, whatever tready does.
- start held high through DONE does not restart streaming; start must drop first.
- start while busy is ignored; cfg_k changes mid-run are ignored.
- Reset mid-stream: next cycle the state is IDLE, both tvalid are 0, and the partial packet is abandoned.

Decomposition:
- Package operand_streamer_pkg holds:
  - state_t enum
  - BANK_A/BANK_B select constants
  - ERR codes (cfg, write)
- Sub-module axis_out_slice (one instance per stream): single-register AXI-Stream output stage with load/hold logic.

Test Plan:
- Basic run: write A[i]=0x100+i and B[i]=0x200+i for i=0..7; cfg_k=4; start=1; tready=1 -> A beats 0x100..0x107 with tlast on 0x107; then B beats 0x200..0x207 with tlast on 0x207; done=1; done clears 1 cycle after start drops.
- Backpressure: as basic run, with A tready toggling 1,0,0,1 -> 8 A beats, none duplicated or skipped; tdata stable during every stall; B tvalid stays 0 until the A tlast handshake.
- Config errors: start with cfg_k=0 -> err pulse 1 cycle, state stays IDLE, no tvalid; cfg_k=K_MAX+1 -> same response; cfg_k=K_MAX -> 128 beats per stream.
- Write guard: a write during STREAM_A -> err pulse and bank unchanged (a second run streams the old data); wr_addr=2*K_MAX in IDLE -> err pulse.
- Reset mid-stream: assert rst after 3 A handshakes -> next cycle tvalid=0, busy=0; a subsequent cfg_k=2 start streams 4 A beats from address 0.
- Edge case cfg_k=1: A and B each emit 2 beats; tlast on the second beat of each; start held high in DONE does not retrigger.

Source files
------------

// File: rtl/operand_streamer_pkg.sv
// Shared types and constants for the operand streamer: FSM states, bank selects, error sources.
package operand_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM_A = 2'd1,
    STREAM_B = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  localparam int unsigned ERR_CFG = 0;
  localparam int unsigned ERR_WR  = 1;
  localparam int unsigned ERR_N   = 2;

endpackage

// File: rtl/operand_streamer_axis_out_slice.sv
// Single-register AXI-Stream output stage: loads a new beat when empty or draining,
// otherwise holds tdata/tlast stable under backpressure.
module axis_out_slice #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_req_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              tready_i,
  output logic [DATA_W-1:0] tdata_o,
  output logic              tvalid_o,
  output logic              tlast_o,
  output logic              load_c_o
);

  logic [DATA_W-1:0] tdata_q;
  logic              tvalid_q;
  logic              tlast_q;

  // A new beat may enter only when the register is empty or its beat leaves this cycle.
  assign load_c_o = load_req_i && (!tvalid_q || tready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else if (load_c_o) begin
      tdata_q  <= data_i;
      tvalid_q <= 1'b1;
      tlast_q  <= last_i;
    end else if (tready_i) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end
  end

  assign tdata_o  = tdata_q;
  assign tvalid_o = tvalid_q;
  assign tlast_o  = tlast_q;

endmodule

// File: rtl/operand_streamer.sv
// Operand feeder for the matrix compute stage: host-loaded A/B banks replayed as two
// AXI-Stream packets of 2*k words each, A first, then B.
module operand_streamer
  import operand_streamer_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned K_MAX  = 64,
  parameter int unsigned ADDR_W = $clog2(2*K_MAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [15:0]       cfg_k,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] m_axis_a_tdata,
  output logic              m_axis_a_tvalid,
  output logic              m_axis_a_tlast,
  input  logic              m_axis_a_tready,
  output logic [DATA_W-1:0] m_axis_b_tdata,
  output logic              m_axis_b_tvalid,
  output logic              m_axis_b_tlast,
  input  logic              m_axis_b_tready
);

  localparam int unsigned DEPTH = 2 * K_MAX;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned KL_W  = $clog2(K_MAX + 1);

  logic [DATA_W-1:0] bank_a [DEPTH];
  logic [DATA_W-1:0] bank_b [DEPTH];

  state_t            state_q;
  logic [KL_W-1:0]   k_lat_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [CNT_W-1:0]  beats_total;
  logic              cnt_done;
  logic              beat_last;
  logic [IDX_W-1:0]  rd_idx;
  logic              cfg_ok;
  logic              wr_in_range;
  logic              wr_ok;
  logic [ERR_N-1:0]  err_vec;
  logic              load_a, load_b;
  logic              a_last_hs, b_last_hs;

  assign beats_total = CNT_W'({k_lat_q, 1'b0});
  assign cnt_done    = (cnt_q == beats_total);
  assign beat_last   = (cnt_q == beats_total - CNT_W'(1));
  assign rd_idx      = cnt_q[IDX_W-1:0];

  assign cfg_ok      = (cfg_k != 16'd0) && (cfg_k <= 16'(K_MAX));
  assign wr_in_range = (CNT_W'(wr_addr) < CNT_W'(DEPTH));
  assign wr_ok       = wr_en && (state_q == IDLE) && wr_in_range;

  assign a_last_hs = m_axis_a_tvalid && m_axis_a_tready && m_axis_a_tlast;
  assign b_last_hs = m_axis_b_tvalid && m_axis_b_tready && m_axis_b_tlast;

  // Error sources collapse into a single one-cycle pulse.
  always_comb begin
    err_vec         = '0;
    err_vec[ERR_WR]  = wr_en && !wr_ok;
    err_vec[ERR_CFG] = (state_q == IDLE) && start && !cfg_ok;
  end

  // Operand banks are storage only; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok && (wr_sel == BANK_A)) bank_a[wr_addr[IDX_W-1:0]] <= wr_data;
    if (wr_ok && (wr_sel == BANK_B)) bank_b[wr_addr[IDX_W-1:0]] <= wr_data;
  end

  // Control FSM; beat counter restarts on every stream entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_lat_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= |err_vec;
      if (load_a || load_b) cnt_q <= cnt_q + CNT_W'(1);
      case (state_q)
        IDLE: begin
          if (start && cfg_ok) begin
            state_q <= STREAM_A;
            k_lat_q <= KL_W'(cfg_k);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        STREAM_A: begin
          if (a_last_hs) begin
            state_q <= STREAM_B;
            cnt_q   <= '0;
          end
        end
        STREAM_B: begin
          if (b_last_hs) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          if (!start) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  axis_out_slice #(.DATA_W(DATA_W)) u_slice_a (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_req_i ((state_q == STREAM_A) && !cnt_done),
    .data_i     (bank_a[rd_idx]),
    .last_i     (beat_last),
    .tready_i   (m_axis_a_tready),
    .tdata_o    (m_axis_a_tdata),
    .tvalid_o   (m_axis_a_tvalid),
    .tlast_o    (m_axis_a_tlast),
    .load_c_o   (load_a)
  );

  axis_out_slice #(.DATA_W(DATA_W)) u_slice_b (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_req_i ((state_q == STREAM_B) && !cnt_done),
    .data_i     (bank_b[rd_idx]),
    .last_i     (beat_last),
    .tready_i   (m_axis_b_tready),
    .tdata_o    (m_axis_b_tdata),
    .tvalid_o   (m_axis_b_tvalid),
    .tlast_o    (m_axis_b_tlast),
    .load_c_o   (load_b)
  );

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_operand_streamer.sv
// Directed bench for operand_streamer: basic replay, backpressure, config and write
// guards, reset mid-stream and the k=1 edge case.
module tb_operand_streamer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned K_MAX  = 64;
  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en, wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [15:0]       cfg_k;
  logic              start;
  logic              busy, done, err;
  logic [DATA_W-1:0] a_tdata, b_tdata;
  logic              a_tvalid, a_tlast, a_ready;
  logic              b_tvalid, b_tlast, b_ready;

  int checks = 0;
  int failures = 0;

  logic [DATA_W:0] a_q[$];
  logic [DATA_W:0] b_q[$];
  int overlap_cnt, b_early_cnt, stall_err_cnt, stall_cnt;
  bit a_last_seen;
  bit prev_stall;
  logic [DATA_W-1:0] prev_data;
  logic prev_last;
  bit [3:0] bp_pat = 4'b1001;

  always #5 clk = ~clk;

  operand_streamer #(.DATA_W(DATA_W), .K_MAX(K_MAX), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .cfg_k(cfg_k), .start(start),
    .busy(busy), .done(done), .err(err),
    .m_axis_a_tdata(a_tdata), .m_axis_a_tvalid(a_tvalid), .m_axis_a_tlast(a_tlast),
    .m_axis_a_tready(a_ready),
    .m_axis_b_tdata(b_tdata), .m_axis_b_tvalid(b_tvalid), .m_axis_b_tlast(b_tlast),
    .m_axis_b_tready(b_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stream monitor on the falling edge: records handshakes and protocol violations.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (a_tvalid && b_tvalid) overlap_cnt++;
      if (b_tvalid && !a_last_seen) b_early_cnt++;
      if (prev_stall && (!a_tvalid || a_tdata !== prev_data || a_tlast !== prev_last))
        stall_err_cnt++;
      if (a_tvalid && !a_ready) stall_cnt++;
      prev_stall = a_tvalid && !a_ready;
      prev_data  = a_tdata;
      prev_last  = a_tlast;
      if (a_tvalid && a_ready) begin
        a_q.push_back({a_tlast, a_tdata});
        if (a_tlast) a_last_seen = 1'b1;
      end
      if (b_tvalid && b_ready) b_q.push_back({b_tlast, b_tdata});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input int addr, input logic [DATA_W-1:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = ADDR_W'(addr); wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_run(input int k);
    a_q.delete(); b_q.delete();
    overlap_cnt = 0; b_early_cnt = 0; stall_err_cnt = 0; stall_cnt = 0;
    a_last_seen = 1'b0;
    cfg_k = 16'(k);
    start = 1'b1;
    tick();
  endtask

  task automatic finish_run(input int k, input bit bp, input int hold, input string tag);
    int cyc = 0;
    while (!done && cyc < 1000) begin
      if (bp) a_ready = bp_pat[cyc % 4];
      tick();
      cyc++;
    end
    a_ready = 1'b1;
    check({tag, "_done"}, 64'(done), 64'd1);
    if (hold > 0) begin
      repeat (hold) tick();
      check({tag, "_hold_done"}, 64'(done), 64'd1);
      check({tag, "_hold_busy"}, 64'(busy), 64'd1);
    end
    check({tag, "_a_len"}, 64'(a_q.size()), 64'(2*k));
    check({tag, "_b_len"}, 64'(b_q.size()), 64'(2*k));
    foreach (a_q[i]) begin
      check($sformatf("%s_a_data%0d", tag, i), 64'(a_q[i][DATA_W-1:0]), 64'(32'h100 + i));
      check($sformatf("%s_a_last%0d", tag, i), 64'(a_q[i][DATA_W]), 64'(i == 2*k-1));
    end
    foreach (b_q[i]) begin
      check($sformatf("%s_b_data%0d", tag, i), 64'(b_q[i][DATA_W-1:0]), 64'(32'h200 + i));
      check($sformatf("%s_b_last%0d", tag, i), 64'(b_q[i][DATA_W]), 64'(i == 2*k-1));
    end
    check({tag, "_overlap"}, 64'(overlap_cnt), 64'd0);
    check({tag, "_b_early"}, 64'(b_early_cnt), 64'd0);
    check({tag, "_stall_hold"}, 64'(stall_err_cnt), 64'd0);
    start = 1'b0;
    tick();
    check({tag, "_done_clr"}, 64'(done), 64'd0);
    check({tag, "_busy_clr"}, 64'(busy), 64'd0);
  endtask

  task automatic cfg_err(input int k, input string tag);
    cfg_k = 16'(k);
    start = 1'b1;
    tick();
    check({tag, "_err"}, 64'(err), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    start = 1'b0;
    tick();
    check({tag, "_err_clr"}, 64'(err), 64'd0);
    check({tag, "_busy2"}, 64'(busy), 64'd0);
    check({tag, "_a_valid"}, 64'(a_tvalid), 64'd0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    cfg_k = 16'd0; start = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_a_valid", 64'(a_tvalid), 64'd0);
    check("rst_b_valid", 64'(b_tvalid), 64'd0);
    check("rst_a_last", 64'(a_tlast), 64'd0);
    check("rst_a_data", 64'(a_tdata), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 2*K_MAX; i++) begin
      wr(1'b0, i, 32'h100 + i);
      wr(1'b1, i, 32'h200 + i);
    end
    check("wr_ok_no_err", 64'(err), 64'd0);

    // Basic run; cfg_k change after start must be ignored.
    start_run(4);
    cfg_k = 16'd9;
    finish_run(4, 1'b0, 0, "basic");

    start_run(4);
    finish_run(4, 1'b1, 0, "bp");
    check("bp_stalls_seen", 64'(stall_cnt > 0), 64'd1);

    cfg_err(0, "cfg0");
    cfg_err(K_MAX + 1, "cfg_big");

    start_run(K_MAX);
    finish_run(K_MAX, 1'b0, 0, "kmax");

    // Write while streaming is dropped.
    start_run(4);
    check("wg_busy", 64'(busy), 64'd1);
    wr(1'b0, 0, 32'hDEAD_BEEF);
    check("wg_busy_err", 64'(err), 64'd1);
    finish_run(4, 1'b0, 0, "wg_run");
    wr(1'b0, 2*K_MAX, 32'hDEAD_BEEF);
    check("wg_range_err", 64'(err), 64'd1);
    tick();
    check("wg_range_err_clr", 64'(err), 64'd0);
    start_run(4);
    finish_run(4, 1'b0, 0, "wg_again");

    // Reset after three A handshakes abandons the packet.
    start_run(4);
    cyc = 0;
    while (a_q.size() < 3 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("rst_mid_reach3", 64'(a_q.size()), 64'd3);
    rst = 1'b1;
    start = 1'b0;
    tick();
    check("rst_mid_a_valid", 64'(a_tvalid), 64'd0);
    check("rst_mid_b_valid", 64'(b_tvalid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    rst = 1'b0;
    tick();
    start_run(2);
    finish_run(2, 1'b0, 0, "rst_rerun");

    // k=1 with start held through DONE.
    start_run(1);
    finish_run(1, 1'b0, 5, "k1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
